// File: rtl/ma_pkg.sv
// ---------------------------------------------------------------------------
// ma_pkg -- shared definitions for the moving-average sequencer.
//
// Holds the default widths, the sequencer state encoding and the decode from
// the 2-bit window select to log2 of the window length.
// ---------------------------------------------------------------------------
package ma_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 4;
  // 16 samples of a full-scale 10-bit value fit in 14 bits without wrapping.
  localparam int ACC_W  = DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  localparam logic [1:0] SEL_BYPASS = 2'b00;
  localparam logic [1:0] SEL_N4     = 2'b01;
  localparam logic [1:0] SEL_N8     = 2'b10;
  localparam logic [1:0] SEL_N16    = 2'b11;

  // Window select -> log2(N): 00 -> N=1, 01 -> 4, 10 -> 8, 11 -> 16.
  function automatic logic [2:0] sel_to_log2n(input logic [1:0] sel);
    logic [2:0] r;
    case (sel)
      SEL_N4:  r = 3'd2;
      SEL_N8:  r = 3'd3;
      SEL_N16: r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// ---------------------------------------------------------------------------
// strobe_sync -- brings the asynchronous sample strobe into the clk domain
// and turns each rising edge into a single-cycle pulse.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   strobe_i  raw asynchronous strobe from the pads
//   edge_o    one-cycle pulse per rising edge of the synchronised strobe
// ---------------------------------------------------------------------------
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic edge_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [1:0] warm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= strobe_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  // The flops come out of reset at 0, so a strobe that is already high at
  // release would look like a rising edge. Edges are only honoured once
  // prev_q holds a genuinely sampled value (three clocks after release).
  assign edge_o = (warm_q == 2'd3) & sync2_q & ~prev_q;

endmodule

// File: rtl/moving_average_sequencer.sv
// ---------------------------------------------------------------------------
// moving_average_sequencer -- boxcar moving-average filter over 1/4/8/16
// samples, using an external synchronous-read window buffer.
//
// Each strobe edge runs IDLE -> READ -> UPDATE -> OUTPUT. READ fetches the
// oldest sample at wptr, UPDATE adds the new sample, drops the oldest one
// once the window is full and overwrites it in the buffer, OUTPUT presents
// acc >> log2(N) with a one-cycle strobe_out.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ena              accept new strobe edges while high
//   sample_in        unsigned sample, captured on the strobe edge
//   strobe_in        asynchronous sample strobe (rising edge = new sample)
//   filter_select    window select, captured with the sample
//   mem_addr/we/wdata/rdata   window-buffer port (rdata one cycle after addr)
//   data_out         filter result
//   strobe_out       one-cycle pulse marking a new data_out
//   busy             sequencer not idle
//   overrun          sticky: a strobe edge arrived while busy
// ---------------------------------------------------------------------------
module moving_average_sequencer #(
  parameter int DATA_W = ma_pkg::DATA_W,
  parameter int ADDR_W = ma_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              strobe_in,
  input  logic [1:0]        filter_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              busy,
  output logic              overrun
);

  import ma_pkg::*;

  localparam int ACC_W_L = DATA_W + ADDR_W;

  state_e              state_q,      state_d;
  logic [DATA_W-1:0]   sample_q,     sample_d;
  logic [1:0]          sel_q,        sel_d;
  logic [1:0]          active_q,     active_d;
  logic [ACC_W_L-1:0]  acc_q,        acc_d;
  logic [ADDR_W:0]     fill_q,       fill_d;
  logic [ADDR_W-1:0]   wptr_q,       wptr_d;
  logic [DATA_W-1:0]   data_out_q,   data_out_d;
  logic                strobe_out_q, strobe_out_d;
  logic                overrun_q,    overrun_d;

  logic                edge_pulse;
  logic [2:0]          shift_w;
  logic [ADDR_W:0]     n_w;
  logic [DATA_W-1:0]   oldest_w;
  logic                bypass_w;
  logic                mem_we_w;

  strobe_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (strobe_in),
    .edge_o   (edge_pulse)
  );

  // Window geometry always follows the active selection; by UPDATE any
  // selection change has already been folded in by the READ-state flush.
  assign shift_w  = sel_to_log2n(active_q);
  assign n_w      = {{ADDR_W{1'b0}}, 1'b1} << shift_w;
  assign bypass_w = (active_q == SEL_BYPASS);
  // The oldest sample only leaves the sum once the window is full.
  assign oldest_w = (fill_q == n_w) ? mem_rdata : '0;

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    sel_d        = sel_q;
    active_d     = active_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    wptr_d       = wptr_q;
    data_out_d   = data_out_q;
    strobe_out_d = 1'b0;
    overrun_d    = overrun_q;
    mem_we_w     = 1'b0;

    // Edges that land while a sequence is running are lost, not queued.
    if (edge_pulse && ena && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (edge_pulse && ena) begin
          sample_d = sample_in;
          sel_d    = filter_select;
          state_d  = ST_READ;
        end
      end

      ST_READ: begin
        // mem_addr already presents wptr; mem_rdata is valid in UPDATE.
        // A new window length invalidates the buffered history, so start
        // over and treat this sample as the first of the new window.
        if (sel_q != active_q) begin
          acc_d    = '0;
          fill_d   = '0;
          wptr_d   = '0;
          active_d = sel_q;
        end
        state_d = ST_UPDATE;
      end

      ST_UPDATE: begin
        if (bypass_w) begin
          // N=1: the buffer is left untouched and the sample passes through.
          acc_d = ACC_W_L'(sample_q);
        end else begin
          mem_we_w = 1'b1;
          acc_d    = acc_q + ACC_W_L'(sample_q) - ACC_W_L'(oldest_w);
          wptr_d   = ({1'b0, wptr_q} == (n_w - 1'b1)) ? '0
                                                       : wptr_q + ADDR_W'(1);
          fill_d   = (fill_q == n_w) ? n_w : fill_q + (ADDR_W+1)'(1);
        end
        // Result is registered on entry to OUTPUT so that data_out and
        // strobe_out are valid together during the OUTPUT cycle. The
        // divide is by N even before the window has filled.
        data_out_d   = DATA_W'(acc_d >> shift_w);
        strobe_out_d = 1'b1;
        state_d      = ST_OUTPUT;
      end

      ST_OUTPUT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sample_q     <= '0;
      sel_q        <= SEL_BYPASS;
      active_q     <= SEL_BYPASS;
      acc_q        <= '0;
      fill_q       <= '0;
      wptr_q       <= '0;
      data_out_q   <= '0;
      strobe_out_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      sel_q        <= sel_d;
      active_q     <= active_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      wptr_q       <= wptr_d;
      data_out_q   <= data_out_d;
      strobe_out_q <= strobe_out_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem_addr   = wptr_q;
  assign mem_we     = mem_we_w;
  assign mem_wdata  = sample_q;
  assign data_out   = data_out_q;
  assign strobe_out = strobe_out_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: doc/moving_average_sequencer.md
MOVING_AVERAGE_SEQUENCER -- requirements
Module: moving_average_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 10, sample and result width.
REQ-002 SHALL have parameter ADDR_W, default 4, window-buffer address width (max window 16).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  input  1  enable; when low, new strobe edges are ignored.
REQ-006 SHALL have port sample_in  input  DATA_W  unsigned sample from pads.
REQ-007 SHALL have port strobe_in  input  1  asynchronous sample strobe; rising edge = new sample.
REQ-008 SHALL have port filter_select  input  2  window: 00 bypass (N=1), 01 N=4, 10 N=8, 11 N=16.
REQ-009 SHALL have port mem_addr  output  ADDR_W  window-buffer address.
REQ-010 SHALL have port mem_we  output  1  window-buffer write enable.
REQ-011 SHALL have port mem_wdata  output  DATA_W  window-buffer write data.
REQ-012 SHALL have port mem_rdata  input  DATA_W  window-buffer read data, valid one cycle after address (synchronous read).
REQ-013 SHALL have port data_out  output  DATA_W  registered filter result.
REQ-014 SHALL have port strobe_out  output  1  one-cycle pulse marking new data_out.
REQ-015 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-016 SHALL have port overrun  output  1  sticky flag: strobe edge arrived while busy.

Function
REQ-017 SHALL pass strobe_in through a 2-flop synchronizer, then rising-edge detect; edge pulse = 1 cycle (cycle E).
REQ-018 SHALL run FSM IDLE -> READ -> UPDATE -> OUTPUT -> IDLE, one cycle per state.
REQ-019 IDLE: on edge pulse with ena=1, SHALL capture sample_in and filter_select, go READ; otherwise stay.
REQ-020 READ (E+1): SHALL drive mem_addr=wptr, mem_we=0 to fetch oldest sample.
REQ-021 UPDATE (E+2): SHALL set acc <= acc + sample - (fill==N ? mem_rdata : 0), write sample at wptr (mem_we=1), wptr <= (wptr==N-1) ? 0 : wptr+1, fill <= min(fill+1, N).
REQ-022 OUTPUT (E+3): SHALL register data_out <= acc >> log2(N) and assert strobe_out for exactly that cycle.
REQ-023 Accumulator SHALL be DATA_W+ADDR_W (14) bits unsigned; no overflow possible (16*1023 < 16384).
REQ-024 Before the window fills, SHALL still divide by N (ramp-up underestimate is intended).
REQ-025 Bypass (00): SHALL keep identical latency, mem_we=0 throughout, data_out = captured sample.
REQ-026 If captured filter_select differs from active selection, SHALL flush (acc=0, fill=0, wptr=0) in READ and treat sample as first of new window.
REQ-027 Edge pulse while busy SHALL be dropped and set overrun; overrun clears only on reset.
REQ-028 ena falling mid-operation SHALL NOT abort the current sequence.
REQ-029 mem_we SHALL be high only in UPDATE; mem_addr SHALL hold wptr otherwise.

Reset
REQ-030 On rst_n low, SHALL asynchronously force FSM=IDLE, acc=0, fill=0, wptr=0, active selection=00, data_out=0, strobe_out=0, mem_we=0, busy=0, overrun=0, synchronizer flops=0.
REQ-031 Reset mid-sequence SHALL abandon the sample; no strobe_out follows.
REQ-032 strobe_in already high at reset release SHALL NOT produce an edge.

Structure
REQ-033 Shared package ma_pkg SHALL hold the state enum, DATA_W/ADDR_W/ACC_W constants and filter_select-to-log2(N) decode.
REQ-034 Synchronizer plus edge detector SHALL be sub-module strobe_sync.

Verification
REQ-035 Select 01, samples 100,200,300,400 -> data_out 25,75,150,250; strobe_out 3 cycles after each edge pulse.
REQ-036 Select 01, 5th sample 500 after above -> oldest (100) read back, data_out 350, mem write at addr 0.
REQ-037 Select 00, sample 1023 -> data_out 1023, mem_we never asserted.
REQ-038 Select 11, 16 samples of 1023 -> data_out 1023, acc 16368, wptr wraps to 0.
REQ-039 Two strobe edges 2 cycles apart -> second dropped, overrun=1, one strobe_out.
REQ-040 Change select 01->10 between samples, then sample 800 -> flush, data_out 100.
